// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped serial transmit port.
// Holds bus addresses, the transmit state encoding and status bit positions.
// Imported by io_tx_port; no logic of its own.
package io_pkg;

    localparam logic [15:0] IO_TX_ADDR   = 16'hFFF0;
    localparam logic [15:0] IO_STAT_ADDR = 16'hFFF1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

endpackage

// File: rtl/io_byte_fifo.sv
// Synchronous byte FIFO, DEPTH entries (power of two), head visible combinationally.
// Ports: clk/reset (sync, active-high), push/din, pop/dout, full/empty flags.
// Push while full is accepted only if a pop happens in the same cycle; pop while empty is ignored.
module io_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/io_tx_port.sv
// Memory-mapped 8N1 serial transmitter: bus stores queue bytes, an FSM shifts them out on tx.
// Ports: clk/reset (sync, active-high), addr/proc_dout/we bus snoop, io_sel/io_rdata status read, tx/busy.
// tx is registered: start bit appears one cycle after the popping IDLE cycle; frames are 10*CLKS_PER_BIT cycles.
module io_tx_port
    import io_pkg::*;
#(
    parameter logic [15:0] TX_ADDR      = IO_TX_ADDR,
    parameter logic [15:0] STAT_ADDR    = IO_STAT_ADDR,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] proc_dout,
    input  logic        we,
    output logic        io_sel,
    output logic [15:0] io_rdata,
    output logic        tx,
    output logic        busy
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_t   state, state_nxt;
    logic [15:0] baud_cnt, baud_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        tx_nxt;
    logic        overflow;
    logic        push;
    logic        pop;
    logic        stat_wr;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [15:0] status;
    logic        unused_dout_hi;

    assign unused_dout_hi = ^proc_dout[15:8];

    assign push    = we && (addr == TX_ADDR);
    assign stat_wr = we && (addr == STAT_ADDR);
    assign io_sel  = (addr == TX_ADDR) || (addr == STAT_ADDR);
    assign busy    = (state != IDLE);

    always_comb begin
        status             = '0;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_BUSY]  = busy;
        status[STAT_OVF]   = overflow;
    end

    assign io_rdata = (addr == STAT_ADDR) ? status : 16'h0000;

    io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (proc_dout[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky overflow; a dropped byte in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (stat_wr && proc_dout[STAT_OVF]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
        end
    end

    // tx_nxt is the line level of the state being entered, so tx lines up with state.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                // Registered empty flag: a push landing this cycle waits until next cycle.
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = fifo_dout;
                    baud_nxt  = '0;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        tx_nxt  = shift[1];
                    end
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_io_tx_port.sv
// Directed bench for io_tx_port with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
// Frames are checked cycle by cycle against the expected 8N1 waveform.
module tb_io_tx_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] proc_dout;
    logic        we;
    logic        io_sel;
    logic [15:0] io_rdata;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;
    int idle_a;
    int idle_b;

    always #5 clk = ~clk;

    io_tx_port #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .proc_dout (proc_dout),
        .we        (we),
        .io_sel    (io_sel),
        .io_rdata  (io_rdata),
        .tx        (tx),
        .busy      (busy)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        addr      = a;
        proc_dout = d;
        we        = 1'b1;
        step();
        we        = 1'b0;
        addr      = 16'h0000;
        proc_dout = 16'h0000;
    endtask

    // Counts idle samples (tx high) before the start bit, bounded by limit.
    task automatic wait_start(input int limit, output int idle);
        idle = 0;
        while (tx !== 1'b0 && idle < limit) begin
            idle++;
            step();
        end
    endtask

    // Starts on the first start-bit sample; returns on the first sample after the stop bit.
    task automatic expect_frame(input logic [7:0] b, input string tag);
        int   bad;
        int   slot;
        logic e;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            slot = i / 4;
            if (slot == 0)      e = 1'b0;
            else if (slot == 9) e = 1'b1;
            else                e = b[slot-1];
            if (tx !== e || busy !== 1'b1) bad++;
            step();
        end
        chk(tag, 16'(bad), 16'd0);
    endtask

    task automatic expect_quiet(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
            step();
        end
        chk(tag, 16'(bad), 16'd0);
    endtask

    initial begin
        reset     = 1'b1;
        addr      = 16'h0000;
        proc_dout = 16'h0000;
        we        = 1'b0;
        step();
        step();
        chk("reset_tx", {15'd0, tx}, 16'd1);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        reset = 1'b0;

        // Quiet after reset.
        expect_quiet(50, "idle50");
        addr = 16'hFFF1;
        #1;
        chk("idle_stat", io_rdata, 16'h0002);
        chk("stat_sel", {15'd0, io_sel}, 16'd1);

        // Single byte; upper data bits must not matter.
        fork
            bus_write(16'hFFF0, 16'hAB55);
            begin
                wait_start(20, idle_a);
                chk("single_idle", 16'(idle_a), 16'd2);
                expect_frame(8'h55, "single_frame");
                chk("single_end_busy", {15'd0, busy}, 16'd0);
                chk("single_end_tx", {15'd0, tx}, 16'd1);
            end
        join
        step();

        // Five back-to-back stores while idle.
        fork
            begin
                for (int k = 1; k <= 5; k++) bus_write(16'hFFF0, 16'(k));
                addr = 16'hFFF1;
                #1;
                chk("five_stat", io_rdata, 16'h0005);
            end
            begin
                wait_start(20, idle_a);
                chk("five_idle0", 16'(idle_a), 16'd2);
                expect_frame(8'h01, "five_frame1");
                for (int k = 2; k <= 5; k++) begin
                    wait_start(20, idle_b);
                    chk("five_gap", 16'(idle_b), 16'd1);
                    expect_frame(8'(k), "five_frame");
                end
            end
        join
        addr = 16'h0000;
        expect_quiet(10, "five_after");
        addr = 16'hFFF1;
        #1;
        chk("five_end_stat", io_rdata, 16'h0002);
        step();

        // Six stores: the sixth overflows and is dropped.
        fork
            begin
                for (int k = 0; k < 6; k++) bus_write(16'hFFF0, 16'h0011 + 16'(k));
                addr = 16'hFFF1;
                #1;
                chk("ovf_stat_busy", io_rdata, 16'h000D);
                for (int k = 0; k < 56; k++) step();
                bus_write(16'hFFF1, 16'h0008);
                addr = 16'hFFF1;
                #1;
                chk("ovf_clear_stat", io_rdata, 16'h0004);
            end
            begin
                wait_start(20, idle_a);
                chk("six_idle0", 16'(idle_a), 16'd2);
                expect_frame(8'h11, "six_frame1");
                chk("six_gap_stat", io_rdata, 16'h0009);
                for (int k = 1; k < 5; k++) begin
                    wait_start(20, idle_b);
                    chk("six_gap", 16'(idle_b), 16'd1);
                    expect_frame(8'h11 + 8'(k), "six_frame");
                end
                expect_quiet(60, "six_no_sixth");
            end
        join
        addr = 16'hFFF1;
        #1;
        chk("six_end_stat", io_rdata, 16'h0002);
        step();

        // Reset at cycle 15 of a frame with two bytes still queued.
        bus_write(16'hFFF0, 16'h0055);
        bus_write(16'hFFF0, 16'h0066);
        bus_write(16'hFFF0, 16'h0077);
        for (int k = 0; k < 14; k++) step();
        addr = 16'hFFF1;
        #1;
        chk("pre_reset_stat", io_rdata, 16'h0004);
        chk("pre_reset_tx", {15'd0, tx}, 16'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("post_reset_tx", {15'd0, tx}, 16'd1);
        chk("post_reset_busy", {15'd0, busy}, 16'd0);
        expect_quiet(60, "post_reset_quiet");
        #1;
        chk("post_reset_stat", io_rdata, 16'h0002);

        // Foreign address: no decode, no queueing.
        addr = 16'h0010;
        #1;
        chk("foreign_sel", {15'd0, io_sel}, 16'd0);
        chk("foreign_rdata", io_rdata, 16'h0000);
        addr = 16'hFFF0;
        #1;
        chk("txaddr_sel", {15'd0, io_sel}, 16'd1);
        chk("txaddr_rdata", io_rdata, 16'h0000);
        step();
        bus_write(16'h0010, 16'h00AA);
        expect_quiet(50, "foreign_quiet");
        addr = 16'hFFF1;
        #1;
        chk("foreign_stat", io_rdata, 16'h0002);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
